// File: rtl/asg_seq_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | asg_ctrl_pkg : shared types and constants for the ASG sequencer          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package asg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int DEF_SEED_BYTES    = 8;
  localparam int DEF_WARMUP_CYCLES = 64;
  localparam int KS_W              = 8;

  // Width of a counter that must hold every value 0..max.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/asg_seq_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | asg_seq_ctrl_if : host, ASG core and keystream signals of the sequencer  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface asg_seq_ctrl_if;
  import asg_ctrl_pkg::*;

  logic            start;
  logic            stop;
  logic [KS_W-1:0] seed_byte;
  logic            seed_valid;
  logic            seed_ready;
  logic            asg_load;
  logic [KS_W-1:0] asg_load_data;
  logic            asg_step;
  logic            asg_bit;
  logic [KS_W-1:0] ks_byte;
  logic            ks_valid;
  logic            ks_ready;
  logic            busy;
  logic [1:0]      state_dbg;

  // Sequencer side.
  modport master (
    input  start, stop, seed_byte, seed_valid, asg_bit, ks_ready,
    output seed_ready, asg_load, asg_load_data, asg_step,
           ks_byte, ks_valid, busy, state_dbg
  );

  // Host / core / consumer side.
  modport slave (
    output start, stop, seed_byte, seed_valid, asg_bit, ks_ready,
    input  seed_ready, asg_load, asg_load_data, asg_step,
           ks_byte, ks_valid, busy, state_dbg
  );

endinterface

`default_nettype wire

// File: rtl/asg_byte_packer.sv
// +--------------------------------------------------------------------------+
// | asg_byte_packer : packs keystream bits MSB-first into bytes with a        |
// |                   valid/ready output register and a stall flag           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module asg_byte_packer
  import asg_ctrl_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            clear,
  input  wire logic            step,
  input  wire logic            bit_in,
  input  wire logic            ks_ready,
  output      logic            stall,
  output      logic [KS_W-1:0] ks_byte,
  output      logic            ks_valid
);

  localparam int CNT_W = $clog2(KS_W);

  logic [KS_W-2:0]  r_sr;
  logic [CNT_W-1:0] r_bitcnt;
  logic [KS_W-1:0]  r_ks_byte;
  logic             r_ks_valid;

  logic             w_last;
  logic             w_complete;
  logic             w_accept;
  logic [KS_W-1:0]  w_next_sr;

  assign w_last     = (r_bitcnt == CNT_W'(KS_W - 1));
  assign w_complete = step & w_last;
  assign w_accept   = r_ks_valid & ks_ready;
  assign w_next_sr  = {r_sr, bit_in};

  // Completing a byte while the previous one is still unaccepted would lose it.
  assign stall = w_last & r_ks_valid & ~ks_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr       <= '0;
      r_bitcnt   <= '0;
      r_ks_byte  <= '0;
      r_ks_valid <= 1'b0;
    end else if (clear) begin
      r_sr       <= '0;
      r_bitcnt   <= '0;
      r_ks_valid <= 1'b0;
    end else begin
      if (step) begin
        r_sr     <= w_next_sr[KS_W-2:0];
        r_bitcnt <= r_bitcnt + CNT_W'(1);
      end
      if (w_complete) begin
        r_ks_byte  <= w_next_sr;
        r_ks_valid <= 1'b1;
      end else if (w_accept) begin
        r_ks_valid <= 1'b0;
      end
    end
  end

  assign ks_byte  = r_ks_byte;
  assign ks_valid = r_ks_valid;

endmodule

`default_nettype wire

// File: rtl/asg_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | asg_seq_ctrl : seeds the ASG core, runs its warm-up and streams packed    |
// |                keystream bytes with back-pressure stalling               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module asg_seq_ctrl
  import asg_ctrl_pkg::*;
#(
  parameter int SEED_BYTES    = DEF_SEED_BYTES,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES
)(
  input  wire logic    clk,
  input  wire logic    rst,
  asg_seq_ctrl_if.master bus
);

  localparam int SEED_W = cnt_w(SEED_BYTES);
  localparam int WARM_W = cnt_w(WARMUP_CYCLES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEED_W-1:0] r_seed_cnt;
  logic [WARM_W-1:0] r_warm_cnt;

  logic w_seed_ready;
  logic w_asg_load;
  logic w_asg_step;
  logic w_seed_last;
  logic w_warm_last;
  logic w_abort;
  logic w_stall;
  logic w_pack_step;

  assign w_seed_last = (r_seed_cnt == SEED_W'(SEED_BYTES - 1));
  assign w_warm_last = (r_warm_cnt == WARM_W'(WARMUP_CYCLES - 1));
  assign w_abort     = bus.stop & (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_seed_ready = 1'b0;
    w_asg_load   = 1'b0;
    w_asg_step   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start & ~bus.stop) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_seed_ready = 1'b1;
        w_asg_load   = bus.seed_valid;
        if (bus.seed_valid & w_seed_last) begin
          w_state_nxt = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        w_asg_step = 1'b1;
        if (w_warm_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_asg_step = ~w_stall;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Both counters return to zero on their terminal count so the next load starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seed_cnt <= '0;
      r_warm_cnt <= '0;
    end else if (w_abort) begin
      r_seed_cnt <= '0;
      r_warm_cnt <= '0;
    end else begin
      if (w_asg_load) begin
        r_seed_cnt <= w_seed_last ? '0 : r_seed_cnt + SEED_W'(1);
      end
      if (r_state == ST_WARMUP) begin
        r_warm_cnt <= w_warm_last ? '0 : r_warm_cnt + WARM_W'(1);
      end
    end
  end

  assign w_pack_step = (r_state == ST_RUN) & w_asg_step;

  asg_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_abort),
    .step     (w_pack_step),
    .bit_in   (bus.asg_bit),
    .ks_ready (bus.ks_ready),
    .stall    (w_stall),
    .ks_byte  (bus.ks_byte),
    .ks_valid (bus.ks_valid)
  );

  assign bus.seed_ready    = w_seed_ready;
  assign bus.asg_load      = w_asg_load;
  assign bus.asg_load_data = bus.seed_byte;
  assign bus.asg_step      = w_asg_step;
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.state_dbg     = r_state;

endmodule

`default_nettype wire

// File: doc/asg_seq_ctrl.md
# asg_seq_ctrl

Sequencer for the alternating-step-generator (ASG) keystream core inside the tt_um top. It accepts seed bytes from the host pins and shifts them into the ASG seed chain. It then clocks the core through a fixed warm-up and packs the resulting keystream bits MSB-first into bytes. Bytes are delivered over a valid/ready handshake, and the core is stalled on back-pressure so no keystream bit is lost.

## Interface
- SEED_BYTES, 8: number of seed bytes shifted into the ASG per load (≥1)
- WARMUP_CYCLES, 64: discarded ASG steps after seeding (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level sampled in IDLE; begins a load sequence
- stop  in  1  abort to IDLE from any non-IDLE state
- seed_byte  in  8  seed data
- seed_valid  in  1  seed_byte valid
- seed_ready  out  1  controller accepts seed byte
- asg_load  out  1  shift asg_load_data into ASG seed chain this cycle
- asg_load_data  out  8  seed byte to ASG
- asg_step  out  1  advance ASG one step this cycle
- asg_bit  in  1  current ASG output bit, sampled in any cycle with asg_step=1
- ks_byte  out  8  packed keystream byte
- ks_valid  out  1  ks_byte valid
- ks_ready  in  1  consumer accepts ks_byte
- busy  out  1  state ≠ IDLE
- state_dbg  out  2  current state encoding

## Operation
- States: IDLE=0, LOAD=1, WARMUP=2, RUN=3.
- **IDLE:**
  - All handshake/strobe outputs are 0; seed_byte is ignored.
  - start=1 → LOAD.
- **LOAD:**
  - seed_ready=1.
  - asg_load = seed_valid & seed_ready, combinational, with asg_load_data = seed_byte.
  - The seed counter increments per handshake.
  - The handshake with count = SEED_BYTES−1 → WARMUP, counter cleared.
- **WARMUP:**
  - asg_step=1 every cycle and asg_bit is ignored.
  - After WARMUP_CYCLES steps → RUN.
- **RUN:**
  - Each step shifts asg_bit into the shift register, `sr <= {sr[6:0], asg_bit}`, and bitcnt increments modulo 8.
  - On the step with bitcnt=7: ks_byte <= {sr[6:0], asg_bit}, ks_valid <= 1.
  - ks_valid clears on ks_valid & ks_ready, unless a new byte completes in the same cycle. In that case ks_byte is replaced and ks_valid stays 1.
- **Stall:** asg_step = 0 in RUN when bitcnt=7 & ks_valid & !ks_ready; otherwise asg_step = 1 in RUN.
- **stop:**
  - Takes priority in any non-IDLE state → IDLE.
  - Clears bitcnt, the seed/warm-up counters and ks_valid.
  - A partial byte is dropped; ks_byte retains its value.
- start outside IDLE is ignored. start and stop both high in IDLE → stay in IDLE.
- Counters are sized $clog2(max+1); no wrap-around in LOAD or WARMUP.

## Timing
- **Reset (asynchronous, immediate):**
  - state=IDLE; all counters 0; sr=0.
  - ks_byte=0x00, ks_valid=0, seed_ready=0, asg_load=0, asg_step=0, busy=0, state_dbg=0.
- **Start:** start high at edge k → LOAD from cycle k+1; seed_ready high in cycle k+1.
- **Load → warm-up:** last seed handshake at edge j → WARMUP from cycle j+1; asg_step high for cycles j+1 … j+WARMUP_CYCLES.
- **Run:**
  - RUN is entered at cycle R = j+WARMUP_CYCLES+1.
  - Bits are sampled in cycles R … R+7; ks_valid=1 from cycle R+8.
  - Sustained throughput is 1 byte / 8 cycles when ks_ready is held high.
- **Combinational outputs:** asg_load, asg_step and seed_ready are combinational from state/counters/inputs. ks_valid and ks_byte are registered.
- **Reset mid-operation:** discards everything; no ASG strobe may be asserted while rst=1.

## Structure
- **Package asg_ctrl_pkg:** state enum (2-bit, encodings above), default SEED_BYTES/WARMUP_CYCLES constants, KS_W=8.
- **Sub-module asg_byte_packer:** shift register, bitcnt, output register, valid/ready logic, stall flag.
- **Top FSM:** the top instantiates asg_byte_packer and holds the FSM plus the seed and warm-up counters.

## Test plan
- **Reset values:** assert rst mid-RUN with ks_valid=1 → all outputs drop to their reset values immediately, state_dbg=0.
- **Seeding and warm-up** (SEED_BYTES=2, WARMUP_CYCLES=4):
  - Stimulus: start, then seeds 0xA5, 0x3C with seed_valid gapped by one idle cycle.
  - Required: exactly 2 asg_load pulses carrying 0xA5 then 0x3C.
  - Required: exactly 4 asg_step cycles before RUN.
- **Packing:** asg_bit stream 1,0,1,1,0,0,1,0 in RUN with ks_ready=1 → ks_byte=0xB2, ks_valid rises at R+8 and lasts 1 cycle.
- **Back-pressure:**
  - Stimulus: ks_ready=0 throughout RUN.
  - Required: exactly 15 asg_step cycles in RUN, then asg_step=0; ks_byte holds the first byte.
  - Release ks_ready → the second byte appears the cycle after the accept, and no bit is lost.
- **Simultaneous accept and complete:**
  - Stimulus: ks_ready=1 exactly on the cycle the next byte completes.
  - Required: ks_valid stays 1 and ks_byte updates to the new value.
- **Abort:**
  - stop during WARMUP → IDLE next cycle, asg_step=0.
  - stop in RUN after 3 bits → ks_valid=0; a subsequent full load/warm-up produces bytes aligned from bit 0.
